// File: rtl/uart_rx_param_if.sv
// ---------------------------------------------------------------------------
// uart_rx_param_if
// Received-word stream from uart_rx_param to its consumer.
//   out_data   : received word, LSB = first bit on the line
//   out_valid  : out_data and the word flags are valid, held until accepted
//   out_ready  : consumer accepts when out_valid && out_ready
//   frame_err  : word flag, a stop-bit vote was 0
//   parity_err : word flag, parity mismatch
//   brk        : word flag, data, parity and stop votes were all 0
//   overrun    : one-clk pulse, a completed word was dropped
// master = receiver side, slave = consumer side.
// ---------------------------------------------------------------------------
interface uart_rx_param_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 frame_err;
   logic                 parity_err;
   logic                 brk;
   logic                 overrun;

   modport master (
      output out_data, out_valid, frame_err, parity_err, brk, overrun,
      input  out_ready
   );

   modport slave (
      input  out_data, out_valid, frame_err, parity_err, brk, overrun,
      output out_ready
   );
endinterface

// File: rtl/uart_rx_param.sv
// ---------------------------------------------------------------------------
// uart_rx_param
// Parametrised UART receiver with oversample-tick timing and 3-sample
// majority voting per bit. Delivers words over a ready/valid stream with
// frame/parity/break flags and an overrun pulse.
//   clk_i    : system clock
//   rst_n_i  : asynchronous active-low reset
//   en_i     : receiver enable, low forces IDLE and drops a partial frame
//   tick_i   : oversample strobe, OVERSAMPLE ticks per bit
//   rx_i     : asynchronous serial input, idle high
//   busy_o   : high from start detection until the frame ends
//   out_if   : received-word stream (master side)
// ---------------------------------------------------------------------------
module uart_rx_param #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              en_i,
   input  logic              tick_i,
   input  logic              rx_i,
   output logic              busy_o,
   uart_rx_param_if.master   out_if
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] C_LO   = CW'(OVERSAMPLE/2 - 1);
   localparam logic [CW-1:0] C_MID  = CW'(OVERSAMPLE/2);
   localparam logic [CW-1:0] C_HI   = CW'(OVERSAMPLE/2 + 1);
   localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [3:0]           idx_q, idx_d;
   logic                 rx_s1_q, rx_s2_q;
   logic                 s0_q, s0_d, s1_q, s1_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 par_q, par_d;      // running XOR of data votes
   logic                 allz_q, allz_d;    // every vote so far was 0
   logic                 ferr_q, ferr_d;
   logic                 perr_q, perr_d;
   logic                 hold_q, hold_d;    // post-break: wait for line high
   logic [DATA_BITS-1:0] odata_q, odata_d;
   logic                 ovalid_q, ovalid_d;
   logic                 ofe_q, ofe_d, ope_q, ope_d, obrk_q, obrk_d;
   logic                 ovr_q, ovr_d;
   logic                 done;
   logic                 rxs, vote, at_hi, at_last;

   assign rxs     = rx_s2_q;
   // Third sample is the live one at cnt = M+1, so the vote is only
   // meaningful on that tick.
   assign vote    = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);
   assign at_hi   = tick_i && (cnt_q == C_HI);
   assign at_last = tick_i && (cnt_q == C_LAST);

   // State register (FSM plus datapath).
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         rx_s1_q  <= 1'b1;
         rx_s2_q  <= 1'b1;
         s0_q     <= 1'b1;
         s1_q     <= 1'b1;
         shreg_q  <= '0;
         par_q    <= 1'b0;
         allz_q   <= 1'b0;
         ferr_q   <= 1'b0;
         perr_q   <= 1'b0;
         hold_q   <= 1'b0;
         odata_q  <= '0;
         ovalid_q <= 1'b0;
         ofe_q    <= 1'b0;
         ope_q    <= 1'b0;
         obrk_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         rx_s1_q  <= rx_i;
         rx_s2_q  <= rx_s1_q;
         s0_q     <= s0_d;
         s1_q     <= s1_d;
         shreg_q  <= shreg_d;
         par_q    <= par_d;
         allz_q   <= allz_d;
         ferr_q   <= ferr_d;
         perr_q   <= perr_d;
         hold_q   <= hold_d;
         odata_q  <= odata_d;
         ovalid_q <= ovalid_d;
         ofe_q    <= ofe_d;
         ope_q    <= ope_d;
         obrk_q   <= obrk_d;
         ovr_q    <= ovr_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      s0_d     = s0_q;
      s1_d     = s1_q;
      shreg_d  = shreg_q;
      par_d    = par_q;
      allz_d   = allz_q;
      ferr_d   = ferr_q;
      perr_d   = perr_q;
      hold_d   = hold_q;
      odata_d  = odata_q;
      ovalid_d = ovalid_q;
      ofe_d    = ofe_q;
      ope_d    = ope_q;
      obrk_d   = obrk_q;
      ovr_d    = 1'b0;
      done     = 1'b0;

      if (!en_i) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         if (tick_i && state_q != S_IDLE) begin
            cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + CW'(1);
            if (cnt_q == C_LO)  s0_d = rxs;
            if (cnt_q == C_MID) s1_d = rxs;
         end

         unique case (state_q)
            S_IDLE: begin
               if (tick_i) begin
                  if (hold_q) begin
                     if (rxs) hold_d = 1'b0;
                  end else if (!rxs) begin
                     // The detect tick is tick 0 of the start bit.
                     state_d = S_START;
                     cnt_d   = CW'(1);
                     idx_d   = '0;
                     par_d   = 1'b0;
                     allz_d  = 1'b1;
                     ferr_d  = 1'b0;
                     perr_d  = 1'b0;
                  end
               end
            end
            S_START: begin
               if (at_hi && vote) begin
                  state_d = S_IDLE;   // false start
                  cnt_d   = '0;
               end else if (at_last) begin
                  state_d = S_DATA;
                  idx_d   = '0;
               end
            end
            S_DATA: begin
               if (at_hi) begin
                  shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                  par_d   = par_q ^ vote;
                  allz_d  = allz_q & ~vote;
               end
               if (at_last) begin
                  if (idx_q == 4'(DATA_BITS-1)) begin
                     idx_d   = '0;
                     state_d = (PARITY != 0) ? S_PAR : S_STOP;
                  end else begin
                     idx_d = idx_q + 4'd1;
                  end
               end
            end
            S_PAR: begin
               if (at_hi) begin
                  perr_d = (PARITY == 1) ? ~(par_q ^ vote) : (par_q ^ vote);
                  allz_d = allz_q & ~vote;
               end
               if (at_last) begin
                  state_d = S_STOP;
                  idx_d   = '0;
               end
            end
            S_STOP: begin
               if (at_hi) begin
                  ferr_d = ferr_q | ~vote;
                  allz_d = allz_q & ~vote;
                  if (idx_q == 4'(STOP_BITS-1)) begin
                     // Return to IDLE mid-stop so a following start edge
                     // is caught without waiting out the stop bit.
                     done    = 1'b1;
                     state_d = S_IDLE;
                     cnt_d   = '0;
                  end
               end else if (at_last) begin
                  idx_d = idx_q + 4'd1;
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      if (done) begin
         hold_d = allz_d;
         if (!ovalid_q || out_if.out_ready) begin
            odata_d  = shreg_q;
            ofe_d    = ferr_d;
            ope_d    = perr_q;
            obrk_d   = allz_d;
            ovalid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (ovalid_q && out_if.out_ready) begin
         ovalid_d = 1'b0;
      end
   end

   // Outputs.
   always_comb begin
      busy_o            = (state_q != S_IDLE);
      out_if.out_data   = odata_q;
      out_if.out_valid  = ovalid_q;
      out_if.frame_err  = ofe_q;
      out_if.parity_err = ope_q;
      out_if.brk        = obrk_q;
      out_if.overrun    = ovr_q;
   end

endmodule

// File: tb/tb_uart_rx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_param
// Bench for uart_rx_param: instance A is 8N1, instance B is 7E1, both at
// OVERSAMPLE=16 with tick held high. Expected words are queued as frames are
// driven and compared as the consumer accepts them.
// ---------------------------------------------------------------------------
module tb_uart_rx_param;
   localparam int OS = 16;

   typedef struct packed {
      logic [8:0] data;
      logic       fe;
      logic       pe;
      logic       brk;
   } word_t;

   typedef struct {
      int         which;
      logic [8:0] data;
      bit         flip;
      bit         stopv;
      word_t      exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n, en, tick, rx_a, rx_b, busy_a, busy_b;
   int   errors = 0, checks = 0, words_a = 0, words_b = 0, ovr_a = 0, cyc = 0;
   word_t qa[$], qb[$];
   word_t ga, gb, ea, eb;
   vec_t  vt[8];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx_param_if #(.DATA_BITS(8)) ifa ();
   uart_rx_param_if #(.DATA_BITS(7)) ifb ();

   uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(1)) dut_a (
      .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .tick_i(tick), .rx_i(rx_a),
      .busy_o(busy_a), .out_if(ifa.master));

   uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(OS), .PARITY(2), .STOP_BITS(1)) dut_b (
      .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .tick_i(tick), .rx_i(rx_b),
      .busy_o(busy_b), .out_if(ifb.master));

   function automatic word_t mk(input logic [8:0] d, input logic fe, input logic pe, input logic b);
      word_t w;
      w.data = d; w.fe = fe; w.pe = pe; w.brk = b;
      return w;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Consumer-side monitor: one negedge per accepted word.
   always @(negedge clk) begin
      if (rst_n && ifa.out_valid && ifa.out_ready) begin
         words_a++;
         ga = mk({1'b0, ifa.out_data}, ifa.frame_err, ifa.parity_err, ifa.brk);
         if (qa.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_word_a: got %0h expected none", ga);
         end else begin
            ea = qa.pop_front();
            chk("word_a", 32'(ga), 32'(ea));
         end
      end
      if (rst_n && ifb.out_valid && ifb.out_ready) begin
         words_b++;
         gb = mk({2'b0, ifb.out_data}, ifb.frame_err, ifb.parity_err, ifb.brk);
         if (qb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_word_b: got %0h expected none", gb);
         end else begin
            eb = qb.pop_front();
            chk("word_b", 32'(gb), 32'(eb));
         end
      end
      if (ifa.overrun) ovr_a++;
   end

   task automatic drv(input int w, input logic v, input int n);
      if (w == 0) rx_a = v; else rx_b = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One frame; instance B gets an even-parity bit (optionally inverted).
   task automatic send(input int w, input logic [8:0] d, input bit flip,
                       input bit stopv, input int stop_ticks);
      int   nd;
      logic p;
      nd = (w == 0) ? 8 : 7;
      p  = 1'b0;
      drv(w, 1'b0, OS);
      for (int i = 0; i < nd; i++) begin
         drv(w, d[i], OS);
         p = p ^ d[i];
      end
      if (w == 1) drv(w, p ^ flip, OS);
      drv(w, stopv, stop_ticks);
      if (!stopv) drv(w, 1'b1, OS);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t0, t1, k, w0, o0;

      vt[0] = '{0, 9'h0A5, 1'b0, 1'b1, mk(9'h0A5, 0, 0, 0)};
      vt[1] = '{0, 9'h03C, 1'b0, 1'b0, mk(9'h03C, 1, 0, 0)};
      vt[2] = '{0, 9'h000, 1'b0, 1'b1, mk(9'h000, 0, 0, 0)};
      vt[3] = '{0, 9'h0FF, 1'b0, 1'b1, mk(9'h0FF, 0, 0, 0)};
      vt[4] = '{1, 9'h041, 1'b1, 1'b1, mk(9'h041, 0, 1, 0)};
      vt[5] = '{1, 9'h041, 1'b0, 1'b1, mk(9'h041, 0, 0, 0)};
      vt[6] = '{1, 9'h000, 1'b1, 1'b1, mk(9'h000, 0, 1, 0)};
      vt[7] = '{1, 9'h07F, 1'b0, 1'b1, mk(9'h07F, 0, 0, 0)};

      rst_n = 1'b0; en = 1'b1; tick = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
      ifa.out_ready = 1'b1; ifb.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid", 32'(ifa.out_valid), 32'd0);
      chk("reset_data", 32'(ifa.out_data), 32'd0);
      chk("reset_flags", 32'({ifa.frame_err, ifa.parity_err, ifa.brk, ifa.overrun}), 32'd0);
      chk("reset_busy", 32'(busy_a), 32'd0);
      rst_n = 1'b1;
      drv(0, 1'b1, 5);

      // 8N1 latency from start-detect to out_valid.
      qa.push_back(mk(9'h0A5, 0, 0, 0));
      fork
         send(0, 9'h0A5, 1'b0, 1'b1, OS);
         begin
            t0 = -1; t1 = -1;
            k = 0;
            while (!busy_a && k < 100) begin @(negedge clk); k++; end
            if (busy_a) t0 = cyc;
            k = 0;
            while (!ifa.out_valid && k < 400) begin @(negedge clk); k++; end
            if (ifa.out_valid && t0 >= 0) t1 = cyc;
            chk("latency_8n1", 32'(t1 - t0), 32'(9*16 + 9));
         end
      join
      drv(0, 1'b1, 20);

      // Table-driven words on both instances.
      for (int i = 0; i < 8; i++) begin
         if (vt[i].which == 0) qa.push_back(vt[i].exp); else qb.push_back(vt[i].exp);
         send(vt[i].which, vt[i].data, vt[i].flip, vt[i].stopv, OS);
         drv(vt[i].which, 1'b1, 8);
      end
      drv(0, 1'b1, 10);
      chk("table_words_b", 32'(words_b), 32'd4);

      // 4-tick low glitch: false start.
      w0 = words_a;
      drv(0, 1'b0, 4);
      chk("glitch_busy_hi", 32'(busy_a), 32'd1);
      drv(0, 1'b1, 30);
      chk("glitch_busy_lo", 32'(busy_a), 32'd0);
      chk("glitch_no_word", 32'(words_a), 32'(w0));

      // 1-tick high glitch at mid-bit of data bit 3 of 0x00.
      qa.push_back(mk(9'h000, 0, 0, 0));
      drv(0, 1'b0, OS * 4);
      drv(0, 1'b0, 8);
      drv(0, 1'b1, 1);
      drv(0, 1'b0, 7);
      drv(0, 1'b0, OS * 4);
      drv(0, 1'b1, OS);
      drv(0, 1'b1, 10);

      // Break: line low for two frame times.
      w0 = words_a;
      qa.push_back(mk(9'h000, 1, 0, 1));
      drv(0, 1'b0, 20 * OS);
      chk("break_one_word", 32'(words_a), 32'(w0 + 1));
      chk("break_held_idle", 32'(busy_a), 32'd0);
      drv(0, 1'b1, 30);
      chk("break_no_more", 32'(words_a), 32'(w0 + 1));
      qa.push_back(mk(9'h081, 0, 0, 0));
      send(0, 9'h081, 1'b0, 1'b1, OS);
      drv(0, 1'b1, 10);

      // Overrun.
      ifa.out_ready = 1'b0;
      o0 = ovr_a;
      send(0, 9'h011, 1'b0, 1'b1, OS);
      drv(0, 1'b1, 8);
      send(0, 9'h022, 1'b0, 1'b1, OS);
      drv(0, 1'b1, 20);
      chk("ovr_pulses", 32'(ovr_a - o0), 32'd1);
      chk("ovr_held_data", 32'(ifa.out_data), 32'h11);
      chk("ovr_valid", 32'(ifa.out_valid), 32'd1);
      qa.push_back(mk(9'h011, 0, 0, 0));
      ifa.out_ready = 1'b1;
      drv(0, 1'b1, 3);
      chk("ovr_drained", 32'(ifa.out_valid), 32'd0);

      // Back-to-back, next start from mid-stop.
      w0 = words_a;
      qa.push_back(mk(9'h001, 0, 0, 0));
      qa.push_back(mk(9'h002, 0, 0, 0));
      qa.push_back(mk(9'h003, 0, 0, 0));
      send(0, 9'h001, 1'b0, 1'b1, 12);
      send(0, 9'h002, 1'b0, 1'b1, 12);
      send(0, 9'h003, 1'b0, 1'b1, OS);
      drv(0, 1'b1, 20);
      chk("b2b_words", 32'(words_a), 32'(w0 + 3));

      // Asynchronous reset during data bit 4 with a word held.
      ifa.out_ready = 1'b0;
      send(0, 9'h077, 1'b0, 1'b1, OS);
      drv(0, 1'b1, 8);
      drv(0, 1'b0, OS);
      drv(0, 1'b1, OS * 3);
      drv(0, 1'b0, OS);
      drv(0, 1'b1, 5);
      chk("pre_reset_busy", 32'(busy_a), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(ifa.out_valid), 32'd0);
      chk("arst_data", 32'(ifa.out_data), 32'd0);
      chk("arst_busy", 32'(busy_a), 32'd0);
      chk("arst_flags", 32'({ifa.frame_err, ifa.parity_err, ifa.brk, ifa.overrun}), 32'd0);
      drv(0, 1'b1, 5);
      rst_n = 1'b1;
      ifa.out_ready = 1'b1;
      drv(0, 1'b1, 20);

      // en low mid-frame, then a clean word.
      w0 = words_a;
      drv(0, 1'b0, OS);
      drv(0, 1'b1, OS);
      drv(0, 1'b0, 10);
      en = 1'b0;
      drv(0, 1'b0, 2);
      chk("en_abort_busy", 32'(busy_a), 32'd0);
      drv(0, 1'b1, 20);
      en = 1'b1;
      drv(0, 1'b1, 10);
      chk("en_abort_no_word", 32'(words_a), 32'(w0));
      qa.push_back(mk(9'h05A, 0, 0, 0));
      send(0, 9'h05A, 1'b0, 1'b1, OS);
      drv(0, 1'b1, 20);
      chk("en_resume_word", 32'(words_a), 32'(w0 + 1));

      chk("queue_a_empty", 32'(qa.size()), 32'd0);
      chk("queue_b_empty", 32'(qb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver, successor to the fixed 8N1 receiver. It adds configurable data width, parity, stop-bit count and oversampling ratio. It runs on the system clock with an oversample tick enable, and takes each bit as a 3-sample majority vote. Received words are delivered over a ready/valid handshake with per-word framing, parity and break flags, and the block reports overrun. It sits between the pad-side rx line and a consumer such as a FIFO or CSR block.

## Interface
- DATA_BITS, 8: data bits per frame, legal 5..9.
- OVERSAMPLE, 16: ticks per bit, even, legal 8..32.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  receiver enable; low forces IDLE synchronously.
- tick  in  1  oversample strobe, one clk wide, OVERSAMPLE per bit period.
- rx  in  1  asynchronous serial input, idle high.
- out_data  out  DATA_BITS  received word, LSB = first bit on the line.
- out_valid  out  1  out_data and flags valid; held until accepted.
- out_ready  in  1  consumer accepts when out_valid and out_ready are both high.
- frame_err  out  1  word flag: a stop-bit sample was 0.
- parity_err  out  1  word flag: parity mismatch (always 0 when PARITY=0).
- brk  out  1  word flag: data, parity and stop all sampled 0.
- overrun  out  1  one-clk pulse: a completed word was dropped.
- busy  out  1  high from start detection until the frame ends.

## Operation
- rx passes through a 2-flop synchroniser (flops reset to 1). All sampling uses the synchronised value, and only on clk edges where tick=1.
- Bit counter cnt counts ticks 0..OVERSAMPLE-1. M = OVERSAMPLE/2. Each bit value is the majority of the samples at cnt = M-1, M and M+1.
- **IDLE:** on a tick with sync rx=0, go to START with cnt=0 and busy=1.
- **START:** at cnt=M+1, a majority of 1 is a false start: go to IDLE, busy=0, no flags. A majority of 0 continues. When cnt reaches OVERSAMPLE-1, cnt goes to 0 and the FSM enters DATA.
- **DATA:** shifts in DATA_BITS bits, LSB first, then goes to PARITY (if PARITY≠0) or to STOP.
- **PARITY:** the sampled bit is checked against the XOR of the data bits (odd: XOR^bit must be 1; even: it must be 0).
- **STOP:** each stop bit is voted. The word completes at cnt=M+1 of the last stop bit. The FSM then returns to IDLE immediately, so the next start edge may arrive from mid-stop onward.
- **Flags:**
  - frame_err = any stop bit voted 0.
  - brk = all data, parity and stop votes were 0.
  - After a brk word, IDLE ignores rx until one tick with sync rx=1.
- **Completion:**
  - If out_valid=0, or out_ready=1 in the same cycle, load out_data and the flags and set out_valid=1.
  - Otherwise keep the old word and its flags, and pulse overrun.
  - Words with errors are still delivered.
- **en=0:** state goes to IDLE, cnt=0 and busy=0; the partial frame is discarded. out_valid and the held word are unaffected and can still be drained.
- **Reset:** out_data=0, out_valid=0, all flags 0, overrun=0, busy=0, state IDLE, cnt=0.

## Timing
- Synchroniser latency is 2 clk.
- Let F = 1 + DATA_BITS + (PARITY≠0) + (STOP_BITS-1). From the start-detect tick, out_valid rises on the clk after the tick at which cnt = M+1 of the last stop bit, i.e. after (F·OVERSAMPLE + M+1) ticks.
- out_valid, out_data and the flags change only on completion or acceptance. Acceptance clears out_valid on the next clk edge.
- overrun is exactly 1 clk wide per dropped word.
- busy falls on the same edge that out_valid rises, or on a false start or en=0.
- tick may be held high every clk; the behaviour is then identical at OVERSAMPLE clk per bit.

## Test plan
- **8N1 receive:** OVERSAMPLE=16, tick every clk, rx=0xA5 at 16 clk/bit, out_ready=1. Required: out_valid pulses with out_data=0xA5, all flags 0, and the rise occurs exactly 9·16+9 ticks after the start-detect tick.
- **Parity:** PARITY=2, DATA_BITS=7. Send 0x41 with the parity bit inverted: delivered word 0x41 with parity_err=1. Resend with correct parity: parity_err=0.
- **Noise rejection:**
  - A 4-tick low glitch on idle rx gives no out_valid and busy returns to 0.
  - A 1-tick high glitch at mid-bit in data bit 3 of 0x00 still delivers 0x00.
- **Break and framing:**
  - rx held low for 2 frame times: word 0x00 with brk=1 and frame_err=1, and no further words until rx returns high.
  - 0x3C with stop bit 0: frame_err=1, brk=0.
- **Overrun and back-to-back:**
  - out_ready=0, send 0x11 then 0x22: one overrun pulse and out_data stays 0x11.
  - Then with out_ready=1, three back-to-back frames 0x01, 0x02, 0x03 (next start at mid-stop) are all delivered in order.
- **Mid-frame abort:**
  - rst_n low during data bit 4: all outputs go to reset values asynchronously.
  - en low mid-frame: no word, busy=0, and a subsequent 0x5A is received correctly.
